alu_result_buffer: RTL and testbench



---
 rtl/alu_result_buffer.sv | 120 ++++++++++++
 tb/tb_alu_result_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Capture FIFO for ALU transactions with valid/ready replay and a saturating drop counter.
// Optional ALU_FLAGS_EN adds out_zero/out_parity flags stored with each entry.
module alu_result_buffer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic [SEL_W-1:0]         sel,
    input  logic [WIDTH-1:0]         result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_A,
    output logic [WIDTH-1:0]         out_B,
    output logic [SEL_W-1:0]         out_sel,
    output logic [WIDTH-1:0]         out_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt
`ifdef ALU_FLAGS_EN
    ,
    output logic                     out_zero,
    output logic                     out_parity
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] result;
`ifdef ALU_FLAGS_EN
        logic             zero;
        logic             parity;
`endif
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Handshake flags come straight from occupancy; no pointer comparison.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_entry        = '0;
        wr_entry.a      = A;
        wr_entry.b      = B;
        wr_entry.sel    = sel;
        wr_entry.result = result;
`ifdef ALU_FLAGS_EN
        wr_entry.zero   = (result == '0);
        wr_entry.parity = ^result;
`endif
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (in_valid && !in_ready && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    // Head entry is masked to zero while empty so stale storage never leaks out.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign out_A      = head.a;
    assign out_B      = head.b;
    assign out_sel    = head.sel;
    assign out_result = head.result;
`ifdef ALU_FLAGS_EN
    assign out_zero   = head.zero;
    assign out_parity = head.parity;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized self-checking bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int          DROP_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] s;
        logic [WIDTH-1:0] r;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [SEL_W-1:0] sel = '0;
    logic [WIDTH-1:0] result = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_A;
    logic [WIDTH-1:0] out_B;
    logic [SEL_W-1:0] out_sel;
    logic [WIDTH-1:0] out_result;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] drop_cnt;
`ifdef ALU_FLAGS_EN
    logic             out_zero;
    logic             out_parity;
`endif

    txn_t model_q[$];
    int   model_drop = 0;
    int   tests = 0;
    int   fails = 0;

    alu_result_buffer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .result(result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .out_sel(out_sel), .out_result(out_result),
        .count(count), .drop_cnt(drop_cnt)
`ifdef ALU_FLAGS_EN
        , .out_zero(out_zero), .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    function automatic txn_t exp_head();
        return (model_q.size() > 0) ? model_q[0] : txn_t'(0);
    endfunction

    function automatic txn_t dut_head();
        return {out_A, out_B, out_sel, out_result};
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] r);
        in_valid = v; A = a; B = b; sel = s; result = r;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, WIDTH'($urandom), WIDTH'($urandom), SEL_W'($urandom), WIDTH'($urandom));
    endtask

    // One clock: reference model applies the rules for the inputs currently applied.
    task automatic step();
        bit acc;
        bit pp;
        acc = in_valid && (model_q.size() < int'(DEPTH));
        pp  = out_ready && (model_q.size() > 0);
        if (in_valid && !acc && model_drop < DROP_MAX) model_drop++;
        @(posedge clk);
        if (pp) void'(model_q.pop_front());
        if (acc) model_q.push_back({A, B, sel, result});
        @(negedge clk);
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 1; i++) step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== '0) begin
            fails++;
            $display("FAIL reset_flags: count=%0d out_valid=%b in_ready=%b drop=%0d, want 0/0/1/0",
                     count, out_valid, in_ready, drop_cnt);
        end
        tests++;
        if (dut_head() !== txn_t'(0)) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", dut_head());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_push();
        drive(1'b1, 4'b0011, 4'b0001, 3'b000, 4'b0100);
        step();
        drive(1'b0, '0, '0, '0, '0);
        tests++;
        if (out_valid !== 1'b1 || out_result !== 4'b0100 || count !== CW'(1)) begin
            fails++;
            $display("FAIL single_push: out_valid=%b result=%b count=%0d, want 1/0100/1",
                     out_valid, out_result, count);
        end
        tests++;
        if (dut_head() !== exp_head()) begin
            fails++;
            $display("FAIL single_push_head: got %h want %h", dut_head(), exp_head());
        end
`ifdef ALU_FLAGS_EN
        tests++;
        if (out_zero !== 1'b0 || out_parity !== 1'b1) begin
            fails++;
            $display("FAIL single_push_flags: zero=%b parity=%b want 0/1", out_zero, out_parity);
        end
`endif
        drain();
    endtask

    task automatic test_fill_and_drop();
        logic [WIDTH-1:0] res [4];
        res[0] = 4'b0100; res[1] = 4'b0011; res[2] = 4'b1000; res[3] = 4'b1110;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), SEL_W'($urandom), res[i]);
            step();
        end
        tests++;
        if (count !== CW'(4) || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill: count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            step();
        end
        drive(1'b0, '0, '0, '0, '0);
        tests++;
        if (drop_cnt !== CNT_W'(3) || drop_cnt !== CNT_W'(model_drop)) begin
            fails++;
            $display("FAIL drop_count: got %0d want 3", drop_cnt);
        end
        tests++;
        if (dut_head() !== exp_head() || count !== CW'(4)) begin
            fails++;
            $display("FAIL full_hold: head %h count %0d, want %h/4", dut_head(), count, exp_head());
        end
    endtask

    task automatic test_drain_order();
        logic [WIDTH-1:0] res [4];
        res[0] = 4'b0100; res[1] = 4'b0011; res[2] = 4'b1000; res[3] = 4'b1110;
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_result !== res[i] || dut_head() !== exp_head()) begin
                fails++;
                $display("FAIL drain_order[%0d]: valid=%b result=%b want 1/%b", i, out_valid, out_result, res[i]);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || dut_head() !== txn_t'(0) || count !== '0) begin
            fails++;
            $display("FAIL drain_empty: valid=%b head=%h count=%0d want 0/0/0", out_valid, dut_head(), count);
        end
    endtask

    task automatic test_back_to_back_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_rand(1'b1);
            tests++;
            if (dut_head() !== exp_head()) begin
                fails++;
                $display("FAIL wrap_head[%0d]: got %h want %h", i, dut_head(), exp_head());
            end
            step();
            tests++;
            if (count !== CW'(2)) begin
                fails++;
                $display("FAIL wrap_count[%0d]: got %0d want 2", i, count);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive_rand(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            out_ready = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            step();
            tests++;
            if (count !== CW'(model_q.size()) || drop_cnt !== CNT_W'(model_drop) ||
                in_ready !== (model_q.size() < int'(DEPTH)) || out_valid !== (model_q.size() > 0)) begin
                fails++;
                $display("FAIL random_state[%0d]: count=%0d drop=%0d in_ready=%b out_valid=%b want count=%0d drop=%0d",
                         i, count, drop_cnt, in_ready, out_valid, model_q.size(), model_drop);
            end
            tests++;
            if (dut_head() !== exp_head()) begin
                fails++;
                $display("FAIL random_head[%0d]: got %h want %h", i, dut_head(), exp_head());
            end
`ifdef ALU_FLAGS_EN
            tests++;
            if (out_zero !== (model_q.size() > 0 && exp_head().r == '0) ||
                out_parity !== (model_q.size() > 0 && (^exp_head().r))) begin
                fails++;
                $display("FAIL random_flags[%0d]: zero=%b parity=%b", i, out_zero, out_parity);
            end
`endif
        end
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_async_reset();
        txn_t t;
        drain();
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            step();
        end
        drive(1'b0, '0, '0, '0, '0);
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        model_drop = 0;
        tests++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== '0 || dut_head() !== txn_t'(0)) begin
            fails++;
            $display("FAIL async_reset: count=%0d valid=%b ready=%b drop=%0d head=%h want 0/0/1/0/0",
                     count, out_valid, in_ready, drop_cnt, dut_head());
        end
        #1 rst = 1'b0;
        drive_rand(1'b1);
        t = {A, B, sel, result};
        step();
        drive(1'b0, '0, '0, '0, '0);
        tests++;
        if (out_valid !== 1'b1 || count !== CW'(1) || dut_head() !== t) begin
            fails++;
            $display("FAIL post_reset_push: valid=%b count=%0d head=%h want 1/1/%h", out_valid, count, dut_head(), t);
        end
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        for (int i = 0; i < 104; i++) begin
            drive_rand(1'b1);
            step();
        end
        tests++;
        if (drop_cnt !== CNT_W'(model_drop)) begin
            fails++;
            $display("FAIL drop_mid: got %0d want %0d", drop_cnt, model_drop);
        end
        for (int i = 0; i < 200; i++) begin
            drive_rand(1'b1);
            step();
        end
        drive(1'b0, '0, '0, '0, '0);
        tests++;
        if (drop_cnt !== CNT_W'(DROP_MAX) || model_drop != DROP_MAX) begin
            fails++;
            $display("FAIL drop_saturate: got %0d want %0d", drop_cnt, DROP_MAX);
        end
        drain();
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags();
        drive(1'b1, 4'b0101, 4'b0101, 3'b001, 4'b0000);
        step();
        drive(1'b0, '0, '0, '0, '0);
        tests++;
        if (out_zero !== 1'b1 || out_parity !== 1'b0) begin
            fails++;
            $display("FAIL zero_flags: zero=%b parity=%b want 1/0", out_zero, out_parity);
        end
        drain();
        tests++;
        if (out_zero !== 1'b0 || out_parity !== 1'b0) begin
            fails++;
            $display("FAIL empty_flags: zero=%b parity=%b want 0/0", out_zero, out_parity);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_fill_and_drop();
        test_drain_order();
        test_back_to_back_wrap();
        test_random();
        test_async_reset();
        test_saturation();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
